// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: qualifies scanner presses, then applies one digit,
// command or function action per press to a 4-digit BCD entry buffer.
module keypad_entry_ctrl #(
  parameter int unsigned HOLD_MIN = 2
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        key_valid,
  input  logic [3:0]  key_value,
  output logic [15:0] digits,
  output logic [2:0]  digit_cnt,
  output logic [13:0] value,
  output logic        value_valid,
  output logic        func_valid,
  output logic [3:0]  func_code,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUALIFY,
    S_ACCEPT,
    S_WAIT_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [13:0] value_q, value_d;
  logic        value_valid_q, value_valid_d;
  logic        func_valid_q, func_valid_d;
  logic [3:0]  func_code_q, func_code_d;
  logic        err_q, err_d;

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    return 14'(bcd[15:12]) * 14'd1000 + 14'(bcd[11:8]) * 14'd100
         + 14'(bcd[7:4]) * 14'd10 + 14'(bcd[3:0]);
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    digits_d      = digits_q;
    digit_cnt_d   = digit_cnt_q;
    value_d       = value_q;
    func_code_d   = func_code_q;
    value_valid_d = 1'b0;
    func_valid_d  = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          state_d = S_QUALIFY;
          cnt_d   = 8'd1;
        end
      end
      S_QUALIFY: begin
        // A release on the very cycle the count matures still counts as a glitch.
        if (!key_valid) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'(HOLD_MIN)) begin
          state_d = S_ACCEPT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACCEPT: begin
        state_d = S_WAIT_RELEASE;
        cnt_d   = 8'd0;
        if (key_value <= 4'd9) begin
          if (digit_cnt_q < 3'd4) begin
            digits_d    = {digits_q[11:0], key_value};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          case (key_value)
            4'hE: begin
              if (digit_cnt_q != 3'd0) begin
                value_d       = bcd_to_bin(digits_q);
                value_valid_d = 1'b1;
                digits_d      = 16'h0000;
                digit_cnt_d   = 3'd0;
              end else begin
                err_d = 1'b1;
              end
            end
            4'hB: begin
              if (digit_cnt_q != 3'd0) begin
                digits_d    = {4'h0, digits_q[15:4]};
                digit_cnt_d = digit_cnt_q - 3'd1;
              end else begin
                err_d = 1'b1;
              end
            end
            4'hC: begin
              digits_d    = 16'h0000;
              digit_cnt_d = 3'd0;
            end
            default: begin
              func_code_d  = key_value;
              func_valid_d = 1'b1;
            end
          endcase
        end
      end
      S_WAIT_RELEASE: begin
        if (!key_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      digits_q      <= 16'h0000;
      digit_cnt_q   <= 3'd0;
      value_q       <= 14'd0;
      value_valid_q <= 1'b0;
      func_valid_q  <= 1'b0;
      func_code_q   <= 4'h0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digits_q      <= digits_d;
      digit_cnt_q   <= digit_cnt_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      func_valid_q  <= func_valid_d;
      func_code_q   <= func_code_d;
      err_q         <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_cnt   = digit_cnt_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign func_valid  = func_valid_q;
  assign func_code   = func_code_q;
  assign err         = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed presses plus random presses, checked
// against a digit-list model of the entry buffer.
module tb_keypad_entry_ctrl;

  localparam int HOLD_MIN = 2;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        key_valid;
  logic [3:0]  key_value;
  logic [15:0] digits;
  logic [2:0]  digit_cnt;
  logic [13:0] value;
  logic        value_valid;
  logic        func_valid;
  logic [3:0]  func_code;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: entered digits, oldest first
  int          dq[$];
  logic [13:0] m_value;
  logic [3:0]  m_func;

  keypad_entry_ctrl #(.HOLD_MIN(HOLD_MIN)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .key_valid   (key_valid),
    .key_value   (key_value),
    .digits      (digits),
    .digit_cnt   (digit_cnt),
    .value       (value),
    .value_valid (value_valid),
    .func_valid  (func_valid),
    .func_code   (func_code),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_digits();
    logic [15:0] r = 16'h0;
    for (int i = 0; i < dq.size(); i++) r = (r << 4) | 16'(dq[i]);
    return r;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".digits"},    32'(digits),    32'(model_digits()));
    check({tag, ".digit_cnt"}, 32'(digit_cnt), 32'(dq.size()));
    check({tag, ".value"},     32'(value),     32'(m_value));
    check({tag, ".func_code"}, 32'(func_code), 32'(m_func));
  endtask

  // One press: key_valid high for 'hold' sampled edges, then low for 'gap' edges.
  task automatic press(input logic [3:0] key, input int hold, input int gap, input bit scramble);
    bit          acc;
    int          e_vv, e_fv, e_err, e_dig;
    int          n_vv, n_fv, n_err, k_vv, k_fv, k_err, k_dig;
    logic [15:0] pre;
    int          sum;
    acc = (hold >= HOLD_MIN + 1);
    e_vv = 0; e_fv = 0; e_err = 0; e_dig = 0;
    pre = model_digits();
    if (acc) begin
      if (key <= 4'd9) begin
        if (dq.size() < 4) begin dq.push_back(int'(key)); e_dig = 1; end
        else e_err = 1;
      end else if (key == 4'hE) begin
        if (dq.size() > 0) begin
          sum = 0;
          foreach (dq[i]) sum = sum * 10 + dq[i];
          m_value = 14'(sum);
          e_vv = 1;
          dq.delete();
        end else e_err = 1;
      end else if (key == 4'hB) begin
        if (dq.size() > 0) begin void'(dq.pop_back()); e_dig = 1; end
        else e_err = 1;
      end else if (key == 4'hC) begin
        dq.delete();
      end else begin
        m_func = key;
        e_fv = 1;
      end
    end

    n_vv = 0; n_fv = 0; n_err = 0;
    k_vv = -1; k_fv = -1; k_err = -1; k_dig = -1;
    key_valid = 1'b1;
    key_value = key;
    for (int k = 0; k < hold + gap; k++) begin
      @(posedge clk);
      #1;
      if (value_valid === 1'b1) begin n_vv++; if (k_vv < 0) k_vv = k; end
      if (func_valid === 1'b1)  begin n_fv++; if (k_fv < 0) k_fv = k; end
      if (err === 1'b1)         begin n_err++; if (k_err < 0) k_err = k; end
      if (k_dig < 0 && digits !== pre) k_dig = k;
      if (k == hold - 1) key_valid = 1'b0;
      else if (scramble && k == HOLD_MIN + 1) key_value = ~key;
    end

    check("n_value_valid", 32'(n_vv), 32'(e_vv));
    check("n_func_valid",  32'(n_fv), 32'(e_fv));
    check("n_err",         32'(n_err), 32'(e_err));
    if (e_vv != 0)  check("lat_value_valid", 32'(k_vv), 32'(HOLD_MIN + 1));
    if (e_fv != 0)  check("lat_func_valid",  32'(k_fv), 32'(HOLD_MIN + 1));
    if (e_err != 0) check("lat_err",         32'(k_err), 32'(HOLD_MIN + 1));
    if (e_dig != 0) check("lat_digits",      32'(k_dig), 32'(HOLD_MIN + 1));
    check_state($sformatf("key%0h", key));
  endtask

  initial begin
    reset_p   = 1'b1;
    key_valid = 1'b0;
    key_value = 4'h0;
    m_value   = 14'd0;
    m_func    = 4'h0;
    #1;
    check("rst.digits",      32'(digits),      32'h0);
    check("rst.digit_cnt",   32'(digit_cnt),   32'h0);
    check("rst.value",       32'(value),       32'h0);
    check("rst.value_valid", 32'(value_valid), 32'h0);
    check("rst.func_valid",  32'(func_valid),  32'h0);
    check("rst.func_code",   32'(func_code),   32'h0);
    check("rst.err",         32'(err),         32'h0);
    repeat (3) @(posedge clk);
    #1 reset_p = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1,2,3,4 then enter
    press(4'h1, 10, 5, 0);
    press(4'h2, 10, 5, 0);
    press(4'h3, 10, 5, 0);
    press(4'h4, 10, 5, 0);
    press(4'hE, 10, 5, 0);
    check("value_1234", 32'(value), 32'd1234);

    // glitches: too short, and dropping exactly when the count matures
    press(4'h5, HOLD_MIN - 1, 3, 0);
    press(4'h5, HOLD_MIN, 3, 0);
    press(4'h7, 1000, 5, 1);
    check("digits_7", 32'(digits), 32'h0007);
    press(4'hC, 6, 3, 0);

    // overflow, backspace, enter
    press(4'h9, 6, 3, 0);
    press(4'h8, 6, 3, 0);
    press(4'h7, 6, 3, 0);
    press(4'h6, 6, 3, 0);
    press(4'h5, 6, 3, 0);
    check("digits_9876", 32'(digits), 32'h9876);
    press(4'hB, 6, 3, 1);
    check("digits_0987", 32'(digits), 32'h0987);
    press(4'hE, HOLD_MIN + 1, 2, 0);
    check("value_987", 32'(value), 32'd987);

    // empty-buffer commands
    press(4'hE, 6, 3, 0);
    press(4'hB, 6, 3, 0);
    press(4'hC, 6, 3, 0);

    // function keys around a partial entry
    press(4'h4, 6, 3, 0);
    press(4'hD, 6, 3, 0);
    press(4'hA, 6, 3, 0);
    press(4'hF, 6, 3, 0);

    // random presses
    for (int i = 0; i < 80; i++) begin
      press(4'($urandom_range(0, 15)), int'($urandom_range(1, 12)),
            int'($urandom_range(2, 6)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of qualification, key still held afterwards
    press(4'h6, 8, 3, 0);
    press(4'hA, 8, 3, 0);
    key_value = 4'h3;
    key_valid = 1'b1;
    @(posedge clk);
    #1 reset_p = 1'b1;
    #1;
    check("mid_rst.digits",      32'(digits),      32'h0);
    check("mid_rst.digit_cnt",   32'(digit_cnt),   32'h0);
    check("mid_rst.value",       32'(value),       32'h0);
    check("mid_rst.value_valid", 32'(value_valid), 32'h0);
    check("mid_rst.func_valid",  32'(func_valid),  32'h0);
    check("mid_rst.func_code",   32'(func_code),   32'h0);
    check("mid_rst.err",         32'(err),         32'h0);
    #2 reset_p = 1'b0;
    dq.delete();
    m_value = 14'd0;
    m_func  = 4'h0;
    press(4'h3, 8, 3, 0);
    press(4'hE, 8, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
